// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 pipeline: default widths, ALU op codes, result-select
// encodings and forwarding-mux selects.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT    = 32;
    localparam int unsigned RADDR_W_DEFAULT = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        FwdReg = 2'b00,
        FwdWb  = 2'b01,
        FwdMem = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/alu.sv
// Combinational XLEN-bit ALU: add/sub/and/or/slt with a zero flag; unused codes give 0.
module alu
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      ALU_CONTROL,
    output logic [XLEN-1:0] RESULT,
    output logic            ZERO
);

    logic slt;

    assign slt = $signed(A) < $signed(B);

    always_comb begin
        RESULT = '0;
        case (ALU_CONTROL)
            ALU_ADD: RESULT = A + B;
            ALU_SUB: RESULT = A - B;
            ALU_AND: RESULT = A & B;
            ALU_OR:  RESULT = A | B;
            ALU_SLT: RESULT = {{(XLEN-1){1'b0}}, slt};
            default: RESULT = '0;
        endcase
    end

    assign ZERO = (RESULT == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU, branch resolution, EX/MEM register.
// Define EX_FWD_EN to build the MEM/WB forwarding muxes; otherwise operands come from ID/EX.
module ex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEFAULT,
    parameter int unsigned RADDR_W = RADDR_W_DEFAULT
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               STALL_E,
    input  logic               FLUSH_E,
    input  logic               VALID_D,
    input  logic [2:0]         ALU_CONTROL_D,
    input  logic               ALU_SRC_D,
    input  logic               REG_WRITE_D,
    input  logic               MEM_WRITE_D,
    input  logic               BRANCH_D,
    input  logic               JUMP_D,
    input  logic [1:0]         RESULT_SRC_D,
    input  logic [XLEN-1:0]    RD1_D,
    input  logic [XLEN-1:0]    RD2_D,
    input  logic [XLEN-1:0]    IMM_EXT_D,
    input  logic [XLEN-1:0]    PC_D,
    input  logic [XLEN-1:0]    PC_PLUS4_D,
    input  logic [RADDR_W-1:0] RS1_D,
    input  logic [RADDR_W-1:0] RS2_D,
    input  logic [RADDR_W-1:0] RD_D,
    input  logic [XLEN-1:0]    RESULT_W,
    input  logic [RADDR_W-1:0] RD_W,
    input  logic               REG_WRITE_W,
    output logic               PC_SRC_E,
    output logic [XLEN-1:0]    PC_TARGET_E,
    output logic [RADDR_W-1:0] RS1_E,
    output logic [RADDR_W-1:0] RS2_E,
    output logic [RADDR_W-1:0] RD_E,
    output logic               RESULT_SRC_E0,
    output logic               VALID_M,
    output logic               REG_WRITE_M,
    output logic               MEM_WRITE_M,
    output logic [1:0]         RESULT_SRC_M,
    output logic [XLEN-1:0]    ALU_RESULT_M,
    output logic [XLEN-1:0]    WRITE_DATA_M,
    output logic [XLEN-1:0]    PC_PLUS4_M,
    output logic [RADDR_W-1:0] RD_M
);

    // ID/EX register
    logic               valid_e_q;
    logic [2:0]         alu_control_e_q;
    logic               alu_src_e_q;
    logic               reg_write_e_q;
    logic               mem_write_e_q;
    logic               branch_e_q;
    logic               jump_e_q;
    logic [1:0]         result_src_e_q;
    logic [XLEN-1:0]    rd1_e_q;
    logic [XLEN-1:0]    rd2_e_q;
    logic [XLEN-1:0]    imm_e_q;
    logic [XLEN-1:0]    pc_e_q;
    logic [XLEN-1:0]    pc_plus4_e_q;
    logic [RADDR_W-1:0] rs1_e_q;
    logic [RADDR_W-1:0] rs2_e_q;
    logic [RADDR_W-1:0] rd_e_q;

    // EX/MEM register
    logic               valid_m_q;
    logic               reg_write_m_q;
    logic               mem_write_m_q;
    logic [1:0]         result_src_m_q;
    logic [XLEN-1:0]    alu_result_m_q;
    logic [XLEN-1:0]    write_data_m_q;
    logic [XLEN-1:0]    pc_plus4_m_q;
    logic [RADDR_W-1:0] rd_m_q;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b_reg;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            issue_m;

    // A flush zeroes the whole entry, not just the controls, so bubbles look identical.
    always_ff @(posedge CLK) begin
        if (!RST || FLUSH_E) begin
            valid_e_q       <= 1'b0;
            alu_control_e_q <= '0;
            alu_src_e_q     <= 1'b0;
            reg_write_e_q   <= 1'b0;
            mem_write_e_q   <= 1'b0;
            branch_e_q      <= 1'b0;
            jump_e_q        <= 1'b0;
            result_src_e_q  <= '0;
            rd1_e_q         <= '0;
            rd2_e_q         <= '0;
            imm_e_q         <= '0;
            pc_e_q          <= '0;
            pc_plus4_e_q    <= '0;
            rs1_e_q         <= '0;
            rs2_e_q         <= '0;
            rd_e_q          <= '0;
        end else if (!STALL_E) begin
            valid_e_q       <= VALID_D;
            alu_control_e_q <= ALU_CONTROL_D;
            alu_src_e_q     <= ALU_SRC_D;
            reg_write_e_q   <= REG_WRITE_D;
            mem_write_e_q   <= MEM_WRITE_D;
            branch_e_q      <= BRANCH_D;
            jump_e_q        <= JUMP_D;
            result_src_e_q  <= RESULT_SRC_D;
            rd1_e_q         <= RD1_D;
            rd2_e_q         <= RD2_D;
            imm_e_q         <= IMM_EXT_D;
            pc_e_q          <= PC_D;
            pc_plus4_e_q    <= PC_PLUS4_D;
            rs1_e_q         <= RS1_D;
            rs2_e_q         <= RS2_D;
            rd_e_q          <= RD_D;
        end
    end

`ifdef EX_FWD_EN
    fwd_sel_e fwd_a_sel;
    fwd_sel_e fwd_b_sel;

    function automatic logic fwd_hit(input logic we, input logic [RADDR_W-1:0] rd,
                                     input logic [RADDR_W-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

    // MEM is younger than WB, so it takes priority.
    always_comb begin
        fwd_a_sel = FwdReg;
        fwd_b_sel = FwdReg;
        if (fwd_hit(reg_write_m_q, rd_m_q, rs1_e_q)) begin
            fwd_a_sel = FwdMem;
        end else if (fwd_hit(REG_WRITE_W, RD_W, rs1_e_q)) begin
            fwd_a_sel = FwdWb;
        end
        if (fwd_hit(reg_write_m_q, rd_m_q, rs2_e_q)) begin
            fwd_b_sel = FwdMem;
        end else if (fwd_hit(REG_WRITE_W, RD_W, rs2_e_q)) begin
            fwd_b_sel = FwdWb;
        end
    end

    always_comb begin
        src_a     = rd1_e_q;
        src_b_reg = rd2_e_q;
        unique case (fwd_a_sel)
            FwdMem:  src_a = alu_result_m_q;
            FwdWb:   src_a = RESULT_W;
            default: src_a = rd1_e_q;
        endcase
        unique case (fwd_b_sel)
            FwdMem:  src_b_reg = alu_result_m_q;
            FwdWb:   src_b_reg = RESULT_W;
            default: src_b_reg = rd2_e_q;
        endcase
    end
`else
    logic unused_wb;

    // Without forwarding the hazard unit stalls, so writeback inputs are not needed here.
    assign unused_wb = ^{RESULT_W, RD_W, REG_WRITE_W};
    assign src_a     = rd1_e_q;
    assign src_b_reg = rd2_e_q;
`endif

    assign src_b = alu_src_e_q ? imm_e_q : src_b_reg;

    alu #(
        .XLEN (XLEN)
    ) u_alu (
        .A           (src_a),
        .B           (src_b),
        .ALU_CONTROL (alu_control_e_q),
        .RESULT      (alu_result),
        .ZERO        (alu_zero)
    );

    // A stalled instruction stays in EX, so MEM sees a bubble rather than a duplicate.
    assign issue_m = valid_e_q & ~STALL_E;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            valid_m_q      <= 1'b0;
            reg_write_m_q  <= 1'b0;
            mem_write_m_q  <= 1'b0;
            result_src_m_q <= '0;
            alu_result_m_q <= '0;
            write_data_m_q <= '0;
            pc_plus4_m_q   <= '0;
            rd_m_q         <= '0;
        end else begin
            valid_m_q      <= issue_m;
            reg_write_m_q  <= reg_write_e_q & ~STALL_E;
            mem_write_m_q  <= mem_write_e_q & ~STALL_E;
            result_src_m_q <= result_src_e_q;
            alu_result_m_q <= alu_result;
            write_data_m_q <= src_b_reg;
            pc_plus4_m_q   <= pc_plus4_e_q;
            rd_m_q         <= rd_e_q;
        end
    end

    assign PC_SRC_E      = valid_e_q & (jump_e_q | (branch_e_q & alu_zero));
    assign PC_TARGET_E   = pc_e_q + imm_e_q;
    assign RS1_E         = rs1_e_q;
    assign RS2_E         = rs2_e_q;
    assign RD_E          = rd_e_q;
    assign RESULT_SRC_E0 = result_src_e_q[0];

    assign VALID_M      = valid_m_q;
    assign REG_WRITE_M  = reg_write_m_q;
    assign MEM_WRITE_M  = mem_write_m_q;
    assign RESULT_SRC_M = result_src_m_q;
    assign ALU_RESULT_M = alu_result_m_q;
    assign WRITE_DATA_M = write_data_m_q;
    assign PC_PLUS4_M   = pc_plus4_m_q;
    assign RD_M         = rd_m_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: transaction-level model of the EX and MEM slots, checked every cycle,
// plus directed cases with literal expectations. Honours EX_FWD_EN like the design.
module tb_ex_stage;
    import riscv_pkg::*;

    logic        CLK = 1'b0;
    logic        RST, STALL_E, FLUSH_E, VALID_D, ALU_SRC_D;
    logic        REG_WRITE_D, MEM_WRITE_D, BRANCH_D, JUMP_D, REG_WRITE_W;
    logic [2:0]  ALU_CONTROL_D;
    logic [1:0]  RESULT_SRC_D;
    logic [31:0] RD1_D, RD2_D, IMM_EXT_D, PC_D, PC_PLUS4_D, RESULT_W;
    logic [4:0]  RS1_D, RS2_D, RD_D, RD_W;
    logic        PC_SRC_E, RESULT_SRC_E0, VALID_M, REG_WRITE_M, MEM_WRITE_M;
    logic [31:0] PC_TARGET_E, ALU_RESULT_M, WRITE_DATA_M, PC_PLUS4_M;
    logic [4:0]  RS1_E, RS2_E, RD_E, RD_M;
    logic [1:0]  RESULT_SRC_M;

    ex_stage #(.XLEN(32), .RADDR_W(5)) dut (
        .CLK(CLK), .RST(RST), .STALL_E(STALL_E), .FLUSH_E(FLUSH_E), .VALID_D(VALID_D),
        .ALU_CONTROL_D(ALU_CONTROL_D), .ALU_SRC_D(ALU_SRC_D), .REG_WRITE_D(REG_WRITE_D),
        .MEM_WRITE_D(MEM_WRITE_D), .BRANCH_D(BRANCH_D), .JUMP_D(JUMP_D),
        .RESULT_SRC_D(RESULT_SRC_D), .RD1_D(RD1_D), .RD2_D(RD2_D), .IMM_EXT_D(IMM_EXT_D),
        .PC_D(PC_D), .PC_PLUS4_D(PC_PLUS4_D), .RS1_D(RS1_D), .RS2_D(RS2_D), .RD_D(RD_D),
        .RESULT_W(RESULT_W), .RD_W(RD_W), .REG_WRITE_W(REG_WRITE_W),
        .PC_SRC_E(PC_SRC_E), .PC_TARGET_E(PC_TARGET_E), .RS1_E(RS1_E), .RS2_E(RS2_E),
        .RD_E(RD_E), .RESULT_SRC_E0(RESULT_SRC_E0), .VALID_M(VALID_M),
        .REG_WRITE_M(REG_WRITE_M), .MEM_WRITE_M(MEM_WRITE_M), .RESULT_SRC_M(RESULT_SRC_M),
        .ALU_RESULT_M(ALU_RESULT_M), .WRITE_DATA_M(WRITE_DATA_M), .PC_PLUS4_M(PC_PLUS4_M),
        .RD_M(RD_M)
    );

    always #5 CLK = ~CLK;

    // One instruction as seen by EX; known=0 marks fields left unspecified (flushed slot).
    typedef struct {
        bit        known;
        bit        valid;
        bit [2:0]  op;
        bit        alu_src, rw, mw, br, jp;
        bit [1:0]  rsrc;
        bit [31:0] rd1, rd2, imm, pc, pc4;
        bit [4:0]  rs1, rs2, rd;
    } ex_t;

    typedef struct {
        bit        known;
        bit        valid, rw, mw;
        bit [1:0]  rsrc;
        bit [31:0] alu, wd, pc4;
        bit [4:0]  rd;
    } m_t;

    ex_t ex, ex_n;
    m_t  m, m_n;
    int  n_chk  = 0;
    int  n_fail = 0;
    bit  chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    function automatic bit [31:0] ref_alu(input bit [2:0] op, input bit [31:0] a,
                                          input bit [31:0] b);
        int sa = a;
        int sb = b;
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

`ifdef EX_FWD_EN
    // Newest producer wins: the instruction in MEM, then the one in writeback.
    function automatic bit [31:0] opnd(input bit [4:0] rs, input bit [31:0] regv);
        if (m.rw && m.rd != 0 && m.rd == rs) return m.alu;
        if (REG_WRITE_W && RD_W != 0 && RD_W == rs) return RESULT_W;
        return regv;
    endfunction
`endif

    task automatic eval_ex(output bit [31:0] res, output bit [31:0] breg, output bit pcsrc);
        bit [31:0] a;
`ifdef EX_FWD_EN
        a    = opnd(ex.rs1, ex.rd1);
        breg = opnd(ex.rs2, ex.rd2);
`else
        a    = ex.rd1;
        breg = ex.rd2;
`endif
        res   = ref_alu(ex.op, a, ex.alu_src ? ex.imm : breg);
        pcsrc = ex.valid && (ex.jp || (ex.br && res == 0));
    endtask

    task automatic model_next();
        bit [31:0] res, breg;
        bit        pcsrc;
        eval_ex(res, breg, pcsrc);
        if (!RST) begin
            ex_n = '{default: 0};
            ex_n.known = 1'b1;
            m_n = '{default: 0};
            m_n.known = 1'b1;
        end else begin
            m_n.known = ex.known && !STALL_E;
            m_n.valid = ex.valid && !STALL_E;
            m_n.rw    = ex.rw && !STALL_E;
            m_n.mw    = ex.mw && !STALL_E;
            m_n.rsrc  = ex.rsrc;
            m_n.alu   = res;
            m_n.wd    = breg;
            m_n.pc4   = ex.pc4;
            m_n.rd    = ex.rd;
            if (FLUSH_E) begin
                ex_n = '{default: 0};
            end else if (STALL_E) begin
                ex_n = ex;
            end else begin
                ex_n = '{known: 1'b1, valid: VALID_D, op: ALU_CONTROL_D, alu_src: ALU_SRC_D,
                         rw: REG_WRITE_D, mw: MEM_WRITE_D, br: BRANCH_D, jp: JUMP_D,
                         rsrc: RESULT_SRC_D, rd1: RD1_D, rd2: RD2_D, imm: IMM_EXT_D,
                         pc: PC_D, pc4: PC_PLUS4_D, rs1: RS1_D, rs2: RS2_D, rd: RD_D};
            end
        end
    endtask

    // Inputs change 2 time units after each rising edge; directed checks sample there too.
    task automatic step();
        model_next();
        @(posedge CLK);
        ex = ex_n;
        m  = m_n;
        #2;
    endtask

    always @(negedge CLK) begin
        bit [31:0] res, breg;
        bit        pcsrc;
        if (chk_en) begin
            eval_ex(res, breg, pcsrc);
            check("pc_src_e", 32'(PC_SRC_E), 32'(pcsrc));
            check("result_src_e0", 32'(RESULT_SRC_E0), 32'(ex.rsrc[0]));
            check("valid_m", 32'(VALID_M), 32'(m.valid));
            check("reg_write_m", 32'(REG_WRITE_M), 32'(m.rw));
            check("mem_write_m", 32'(MEM_WRITE_M), 32'(m.mw));
            if (ex.known) begin
                check("rs1_e", 32'(RS1_E), 32'(ex.rs1));
                check("rs2_e", 32'(RS2_E), 32'(ex.rs2));
                check("rd_e", 32'(RD_E), 32'(ex.rd));
                check("pc_target_e", PC_TARGET_E, ex.pc + ex.imm);
            end
            if (m.known) begin
                check("result_src_m", 32'(RESULT_SRC_M), 32'(m.rsrc));
                check("alu_result_m", ALU_RESULT_M, m.alu);
                check("write_data_m", WRITE_DATA_M, m.wd);
                check("pc_plus4_m", PC_PLUS4_M, m.pc4);
                check("rd_m", 32'(RD_M), 32'(m.rd));
            end
        end
    end

    task automatic drive_d(input ex_t t);
        VALID_D = t.valid; ALU_CONTROL_D = t.op; ALU_SRC_D = t.alu_src;
        REG_WRITE_D = t.rw; MEM_WRITE_D = t.mw; BRANCH_D = t.br; JUMP_D = t.jp;
        RESULT_SRC_D = t.rsrc; RD1_D = t.rd1; RD2_D = t.rd2; IMM_EXT_D = t.imm;
        PC_D = t.pc; PC_PLUS4_D = t.pc4; RS1_D = t.rs1; RS2_D = t.rs2; RD_D = t.rd;
    endtask

    task automatic drive_w(input bit we, input bit [4:0] rd, input bit [31:0] val);
        REG_WRITE_W = we; RD_W = rd; RESULT_W = val;
    endtask

    function automatic ex_t mk(input bit [2:0] op, input bit alu_src, input bit rw,
                               input bit [31:0] rd1, input bit [31:0] rd2,
                               input bit [31:0] imm, input bit [4:0] rs1,
                               input bit [4:0] rs2, input bit [4:0] rd);
        ex_t t = '{default: 0};
        t.known = 1'b1; t.valid = 1'b1; t.op = op; t.alu_src = alu_src; t.rw = rw;
        t.rd1 = rd1; t.rd2 = rd2; t.imm = imm; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
        t.pc = 32'h40; t.pc4 = 32'h44;
        return t;
    endfunction

    function automatic ex_t rand_instr();
        ex_t t = '{default: 0};
        t.known = 1'b1;
        t.valid = $urandom_range(0, 3) != 0;
        t.op = 3'($urandom_range(0, 7));
        t.alu_src = $urandom_range(0, 1) == 1;
        t.rw = $urandom_range(0, 1) == 1;
        t.mw = $urandom_range(0, 3) == 0;
        t.br = $urandom_range(0, 2) == 0;
        t.jp = $urandom_range(0, 7) == 0;
        t.rsrc = 2'($urandom_range(0, 3));
        t.rd1 = $urandom;
        t.rd2 = ($urandom_range(0, 3) == 0) ? t.rd1 : $urandom;
        t.imm = $urandom; t.pc = $urandom; t.pc4 = $urandom;
        t.rs1 = 5'($urandom_range(0, 3));
        t.rs2 = 5'($urandom_range(0, 3));
        t.rd = 5'($urandom_range(0, 3));
        return t;
    endfunction

    task automatic idle(input int n);
        drive_d('{default: 0});
        drive_w(1'b0, 5'd0, 32'd0);
        STALL_E = 1'b0; FLUSH_E = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_alu(input string name, input bit [2:0] op, input bit [31:0] a,
                           input bit [31:0] b, input bit [31:0] exp);
        idle(1);
        drive_d(mk(op, 1'b0, 1'b1, a, b, 32'd0, 5'd24, 5'd25, 5'd26));
        step();
        drive_d('{default: 0});
        step();
        check(name, ALU_RESULT_M, exp);
    endtask

    initial begin
        ex_t t;
        ex = '{default: 0};
        m  = '{default: 0};

        // Reset held low under random traffic
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_d(rand_instr());
            drive_w($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
            STALL_E = $urandom_range(0, 1) == 1;
            FLUSH_E = $urandom_range(0, 1) == 1;
            step();
            chk_en = 1'b1;
        end
        check("reset_pc_src", 32'(PC_SRC_E), 32'd0);
        check("reset_valid_m", 32'(VALID_M), 32'd0);
        check("reset_alu_m", ALU_RESULT_M, 32'd0);
        check("reset_rd_e", 32'(RD_E), 32'd0);
        RST = 1'b1;

        run_alu("add_7_5", ALU_ADD, 32'd7, 32'd5, 32'd12);
        run_alu("sub_3_5", ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE);
        run_alu("slt_m1_1", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        run_alu("or_f0_0f", ALU_OR, 32'hF0, 32'h0F, 32'hFF);
        run_alu("op_110", 3'b110, 32'hAB, 32'h12, 32'd0);

        // add x5 = 10 + 20, then two consumers of x5 with stale register values
        idle(2);
        drive_d(mk(ALU_ADD, 1'b0, 1'b1, 32'd10, 32'd20, 32'd0, 5'd1, 5'd2, 5'd5));
        step();
        drive_d(mk(ALU_ADD, 1'b1, 1'b1, 32'd999, 32'd0, 32'd1, 5'd5, 5'd0, 5'd6));
        step();
        drive_d(mk(ALU_ADD, 1'b1, 1'b1, 32'd888, 32'd0, 32'd2, 5'd5, 5'd0, 5'd7));
        step();
`ifdef EX_FWD_EN
        check("fwd_mem", ALU_RESULT_M, 32'd31);
`else
        check("nofwd_mem", ALU_RESULT_M, 32'd1000);
`endif
        drive_d('{default: 0});
        drive_w(1'b1, 5'd5, 32'd30);
        step();
`ifdef EX_FWD_EN
        check("fwd_wb", ALU_RESULT_M, 32'd32);
`else
        check("nofwd_wb", ALU_RESULT_M, 32'd890);
`endif

        // Writes to x0 are never forwarded
        idle(2);
        drive_d(mk(ALU_ADD, 1'b0, 1'b1, 32'd1, 32'd2, 32'd0, 5'd20, 5'd21, 5'd0));
        step();
        drive_d(mk(ALU_ADD, 1'b1, 1'b1, 32'd50, 32'd0, 32'd0, 5'd0, 5'd0, 5'd9));
        step();
        drive_d('{default: 0});
        step();
        check("x0_no_fwd", ALU_RESULT_M, 32'd50);

        // beq taken / not taken
        idle(2);
        t = mk(ALU_SUB, 1'b0, 1'b0, 32'h55, 32'h55, 32'h20, 5'd10, 5'd11, 5'd0);
        t.br = 1'b1; t.pc = 32'h100;
        drive_d(t);
        step();
        check("beq_taken", 32'(PC_SRC_E), 32'd1);
        check("beq_target", PC_TARGET_E, 32'h120);
        t.rd2 = 32'h56;
        drive_d(t);
        step();
        check("beq_not_taken", 32'(PC_SRC_E), 32'd0);

        // One-cycle stall: held in EX, bubble into MEM, then exactly one issue
        idle(2);
        drive_d(mk(ALU_ADD, 1'b0, 1'b1, 32'd100, 32'd1, 32'd0, 5'd15, 5'd16, 5'd12));
        step();
        drive_d(mk(ALU_ADD, 1'b0, 1'b1, 32'd7, 32'd7, 32'd0, 5'd17, 5'd18, 5'd14));
        STALL_E = 1'b1;
        step();
        check("stall_valid_m", 32'(VALID_M), 32'd0);
        check("stall_hold_rd_e", 32'(RD_E), 32'd12);
        STALL_E = 1'b0;
        drive_d('{default: 0});
        step();
        check("stall_issue_valid", 32'(VALID_M), 32'd1);
        check("stall_issue_alu", ALU_RESULT_M, 32'd101);
        step();
        check("stall_no_dup", 32'(VALID_M), 32'd0);

        // Flush together with stall
        idle(2);
        drive_d(mk(ALU_ADD, 1'b0, 1'b1, 32'd3, 32'd4, 32'd0, 5'd15, 5'd16, 5'd13));
        step();
        drive_d(mk(ALU_ADD, 1'b0, 1'b1, 32'd5, 32'd6, 32'd0, 5'd17, 5'd18, 5'd14));
        STALL_E = 1'b1; FLUSH_E = 1'b1;
        step();
        check("flush_stall_rw_m", 32'(REG_WRITE_M), 32'd0);
        STALL_E = 1'b0; FLUSH_E = 1'b0;
        drive_d('{default: 0});
        step();
        check("flush_bubble_rw_m", 32'(REG_WRITE_M), 32'd0);

        // Reset with a store in EX
        idle(2);
        t = mk(ALU_ADD, 1'b1, 1'b0, 32'h200, 32'hAB, 32'd4, 5'd8, 5'd9, 5'd0);
        t.mw = 1'b1;
        drive_d(t);
        step();
        RST = 1'b0;
        drive_d('{default: 0});
        step();
        check("rst_mid_mw", 32'(MEM_WRITE_M), 32'd0);
        RST = 1'b1;
        step();
        check("rst_mid_mw_1", 32'(MEM_WRITE_M), 32'd0);
        step();
        check("rst_mid_mw_2", 32'(MEM_WRITE_M), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive_d(rand_instr());
            drive_w($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom);
            STALL_E = $urandom_range(0, 6) == 0;
            FLUSH_E = $urandom_range(0, 9) == 0;
            RST = $urandom_range(0, 49) != 0;
            step();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
